// File: rtl/reg_des_pkg.sv
// Shared types and defaults for the parallel-to-serial controller and its datapath.
package reg_des_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Counter width that stays at least one bit even for a single-entry range.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reg_des.sv
// Serial shift-register datapath: DEPTH single-bit stages, output taken from the last one.
module reg_des
    import reg_des_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic clock,
    input  logic reset,
    input  logic data_in,
    output logic data_out
);

    logic [DEPTH-1:0] r_stage;

    // Shift chain; stage 0 takes the fed bit, each later stage takes its predecessor.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stage <= {DEPTH{1'b0}};
        end else begin
            r_stage[0] <= data_in;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign data_out = r_stage[DEPTH-1];

endmodule

// File: rtl/reg_des_ctrl.sv
// Parallel-to-serial controller: accepts WIDTH-bit words, feeds them LSB first into a
// DEPTH-stage serial datapath, and tags each bit with valid/last flags that travel alongside.
module reg_des_ctrl
    import reg_des_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             data_out,
    output logic             out_valid,
    output logic             done,
    output logic             busy
);

    localparam int BCW = $clog2(WIDTH);
    localparam int FCW = cnt_width(DEPTH);
    localparam logic [BCW-1:0] BIT_LAST   = BCW'(WIDTH - 1);
    localparam logic [FCW-1:0] FLUSH_LAST = FCW'(DEPTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [BCW-1:0]   r_bit_cnt;
    logic [BCW-1:0]   w_bit_cnt_nxt;
    logic [FCW-1:0]   r_flush_cnt;
    logic [FCW-1:0]   w_flush_cnt_nxt;
    logic [WIDTH-1:0] r_word;
    logic [DEPTH-1:0] r_tag_valid;
    logic [DEPTH-1:0] r_tag_last;

    logic w_hs;
    logic w_in_ready;
    logic w_busy;
    logic w_feed_bit;
    logic w_feed_valid;
    logic w_feed_last;
    logic w_ser_out;

    // State, counters and the captured word.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_bit_cnt   <= {BCW{1'b0}};
            r_flush_cnt <= {FCW{1'b0}};
            r_word      <= {WIDTH{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            if (w_hs) begin
                r_word <= in_data;
            end else begin
                r_word <= r_word;
            end
        end
    end

    // Next-state and counter updates; counters saturate at their terminal values.
    always_comb begin
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_flush_cnt_nxt = r_flush_cnt;
        case (r_state)
            IDLE: begin
                if (w_hs) begin
                    w_state_nxt   = SHIFT;
                    w_bit_cnt_nxt = {BCW{1'b0}};
                end else begin
                    w_state_nxt   = IDLE;
                end
            end
            SHIFT: begin
                if (r_bit_cnt == BIT_LAST) begin
                    if (w_hs) begin
                        w_state_nxt   = SHIFT;
                        w_bit_cnt_nxt = {BCW{1'b0}};
                    end else begin
                        w_state_nxt     = FLUSH;
                        w_flush_cnt_nxt = {FCW{1'b0}};
                    end
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + BCW'(1);
                end
            end
            FLUSH: begin
                if (w_hs) begin
                    w_state_nxt   = SHIFT;
                    w_bit_cnt_nxt = {BCW{1'b0}};
                end else if (r_flush_cnt == FLUSH_LAST) begin
                    w_state_nxt     = IDLE;
                    w_flush_cnt_nxt = {FCW{1'b0}};
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt + FCW'(1);
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_bit_cnt_nxt   = {BCW{1'b0}};
                w_flush_cnt_nxt = {FCW{1'b0}};
            end
        endcase
    end

    // Per-state outputs: readiness and the bit/tags fed into the pipelines.
    always_comb begin
        w_in_ready   = 1'b0;
        w_busy       = 1'b0;
        w_feed_bit   = 1'b0;
        w_feed_valid = 1'b0;
        w_feed_last  = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
            end
            SHIFT: begin
                w_in_ready   = (r_bit_cnt == BIT_LAST);
                w_busy       = 1'b1;
                w_feed_bit   = r_word[r_bit_cnt];
                w_feed_valid = 1'b1;
                w_feed_last  = (r_bit_cnt == BIT_LAST);
            end
            FLUSH: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
            end
            default: begin
                w_in_ready = 1'b0;
                w_busy     = 1'b0;
            end
        endcase
    end

    assign in_ready = w_in_ready & ~reset;
    assign w_hs     = in_valid & in_ready;
    assign busy     = w_busy;

    // Valid/last tags shift in lockstep with the datapath so they stay aligned with each bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tag_valid <= {DEPTH{1'b0}};
            r_tag_last  <= {DEPTH{1'b0}};
        end else begin
            r_tag_valid[0] <= w_feed_valid;
            r_tag_last[0]  <= w_feed_last;
            for (int i = 1; i < DEPTH; i++) begin
                r_tag_valid[i] <= r_tag_valid[i-1];
                r_tag_last[i]  <= r_tag_last[i-1];
            end
        end
    end

    reg_des #(
        .DEPTH (DEPTH)
    ) u_reg_des (
        .clock    (clock),
        .reset    (reset),
        .data_in  (w_feed_bit),
        .data_out (w_ser_out)
    );

    assign data_out  = w_ser_out;
    assign out_valid = r_tag_valid[DEPTH-1];
    assign done      = r_tag_last[DEPTH-1];

endmodule

// File: doc/reg_des_ctrl.md
REG_DES_CTRL -- requirements
Module: reg_des_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, is the number of bits per parallel word (WIDTH >= 2).
REQ-002 Parameter DEPTH, default 4, is the number of stages in the serial shift-register datapath (DEPTH >= 1).
REQ-003 clock  in  1  single system clock; every register updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  a parallel word is offered.
REQ-006 in_data  in  WIDTH  offered word, serialised LSB first.
REQ-007 in_ready  out  1  the controller accepts a word in this cycle.
REQ-008 data_out  out  1  serial bit at the last shift-register stage.
REQ-009 out_valid  out  1  data_out carries a word bit.
REQ-010 done  out  1  one-cycle pulse while the last bit (bit WIDTH-1) of a word is on data_out.
REQ-011 busy  out  1  the state is not IDLE.

Function
REQ-012 A handshake occurs when in_valid and in_ready are both 1 at a rising edge; in_data is captured only at that edge.
REQ-013 The FSM has three states: IDLE, SHIFT and FLUSH.
REQ-014 IDLE: in_ready=1 and a zero is fed to the datapath; a handshake moves the FSM to SHIFT with bit_cnt=0.
REQ-015 SHIFT: each cycle feeds word[bit_cnt] to the datapath with valid tag 1 and increments bit_cnt; in_ready=1 only when bit_cnt=WIDTH-1.
REQ-016 SHIFT exit at bit_cnt=WIDTH-1: a handshake stays in SHIFT with bit_cnt=0, giving back-to-back words with no gap; otherwise the FSM goes to FLUSH with flush_cnt=0.
REQ-017 FLUSH: feeds zeros with valid tag 0 and in_ready=1; a handshake goes to SHIFT with bit_cnt=0; otherwise the FSM goes to IDLE after DEPTH cycles (flush_cnt=DEPTH-1).
REQ-018 Latency: for a handshake at the edge ending cycle 0, bit k is on data_out with out_valid=1 in cycle k+DEPTH+1.
REQ-019 Valid and last-bit tags travel in a DEPTH-stage pipeline aligned with the data; out_valid is the valid tag of the last stage, and done is the last-bit tag of the last stage.
REQ-020 Data bits already in the pipeline keep shifting whatever the FSM state is; a new word never corrupts bits still in flight.
REQ-021 bit_cnt is $clog2(WIDTH) bits wide, and flush_cnt is max(1,$clog2(DEPTH)) bits wide; neither counter ever wraps past its terminal value.

Reset
REQ-022 While reset=1 at an edge: state becomes IDLE, bit_cnt and flush_cnt become 0, all data and tag stages become 0, and the captured word becomes 0.
REQ-023 From the cycle after reset: data_out=0, out_valid=0, done=0, busy=0.
REQ-024 in_ready=0 while reset is asserted, and in_ready=1 in the first cycle after reset is released.
REQ-025 A reset in the middle of a word discards the word and all bits in flight, and no done pulse is produced for it.

Structure
REQ-026 Package reg_des_pkg holds the state enum typedef (IDLE, SHIFT, FLUSH) and the default WIDTH/DEPTH constants.
REQ-027 The data path is one instance of sub-module reg_des (ports clock, reset, data_in, data_out; DEPTH stages); the 2-bit tag pipeline is local to reg_des_ctrl.

Verification (WIDTH=8, DEPTH=4; cycle 0 ends with the handshake)
REQ-028 Reset for 2 cycles, then idle -> data_out=0, out_valid=0, done=0, busy=0, in_ready=1.
REQ-029 Single word 8'hA5 -> data_out=1,0,1,0,0,1,0,1 in cycles 5..12 with out_valid=1; done=1 only in cycle 12; FLUSH in cycles 9..12; IDLE and busy=0 from cycle 13.
REQ-030 Back-to-back 8'hFF then 8'h00, with the second word handshaken in cycle 8 -> out_valid=1 continuously in cycles 5..20, data 1 x8 then 0 x8, done in cycles 12 and 20.
REQ-031 8'h01, then 8'h80 handshaken in cycle 10 during FLUSH -> out_valid=0 in cycles 13..14; second word on data_out in cycles 15..22 (bit 7 = 1 in cycle 22); done in cycles 12 and 22.
REQ-032 8'hA5 with reset=1 at the edge ending cycle 6 -> from cycle 7 data_out=0, out_valid=0, no done pulse, state IDLE; a later 8'h3C serialises correctly.
REQ-033 in_valid=1 held with in_data changing every cycle during SHIFT cycles 1..7 -> the changes are ignored, and only the value present at the handshake edge is serialised.
